// File: rtl/lab_monitor_pkg.sv
// Shared display constants and segment decoding for the lab occupancy monitor.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package lab_monitor_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/comp_debounce.sv
// Two-flop synchroniser and debounce for one active-low "computer in use" line.
// A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module comp_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCW-1:0] CNT_TC = DCW'(DEBOUNCE_CYCLES - 1);

  logic           sync1;
  logic           sync2;
  logic [DCW-1:0] cnt;

  // Sync flops reset to the idle level so release from reset causes no spurious change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      cnt    <= '0;
      stable <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lab_monitor.sv
// Lab occupancy monitor: debounced in-use count, peak tracking and a scanned
// multi-digit 7-segment display of either the current or the peak count.
module lab_monitor
  import lab_monitor_pkg::*;
#(
  parameter int N_COMPS         = 16,
  parameter int N_DIGITS        = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 1024,
  localparam int CW             = $clog2(N_COMPS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_COMPS-1:0]  comps,
  input  logic                show_peak,
  input  logic                clear_peak,
  output logic [CW-1:0]       count,
  output logic [CW-1:0]       peak,
  output logic                full,
  output logic                empty,
  output logic [6:0]          segs,
  output logic [N_DIGITS-1:0] an
);

  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = 4 * N_DIGITS;
  localparam logic [SW-1:0] SCAN_TC   = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_TC  = DW'(N_DIGITS - 1);

  logic [N_COMPS-1:0] stable;
  logic [CW-1:0]      pop;

  for (genvar i = 0; i < N_COMPS; i++) begin : g_db
    comp_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (comps[i]),
      .stable(stable[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_COMPS; i++) begin
      pop = pop + CW'(!stable[i]);
    end
  end

  // clear_peak reloads from the current count, so a rise on that same edge is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      peak  <= '0;
    end else begin
      count <= pop;
      full  <= (pop == CW'(N_COMPS));
      empty <= (pop == '0);
      if (clear_peak || (count > peak)) begin
        peak <= count;
      end
    end
  end

  logic [SW-1:0]       scan_cnt;
  logic [DW-1:0]       digit_idx;
  logic [CW-1:0]       snapshot;
  logic                scan_wrap;
  logic                frame_wrap;
  logic [DW-1:0]       idx_next;
  logic [CW-1:0]       snap_next;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       bcd_upper;
  logic [3:0]          digit;
  logic                blank;
  logic [6:0]          segs_next;
  logic [N_DIGITS-1:0] an_next;

  assign scan_wrap  = (scan_cnt == SCAN_TC);
  assign frame_wrap = scan_wrap && (digit_idx == DIGIT_TC);
  assign idx_next   = !scan_wrap ? digit_idx : (frame_wrap ? '0 : digit_idx + 1'b1);
  // The digit shown after a frame boundary must come from the new snapshot.
  assign snap_next  = frame_wrap ? (show_peak ? peak : count) : snapshot;

  always_comb begin
    bcd = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      for (int d = 0; d < N_DIGITS; d++) begin
        if (bcd[4*d +: 4] > 4'd4) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[BW-2:0], snap_next[i]};
    end
  end

  assign digit     = bcd[4*int'(idx_next) +: 4];
  assign bcd_upper = bcd >> (4 * int'(idx_next));
  assign blank     = (idx_next != '0) && (bcd_upper == '0);
  assign segs_next = blank ? SEG_BLANK : seg_decode(digit);
  assign an_next   = N_DIGITS'(1) << idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      snapshot  <= '0;
      segs      <= SEG_0;
      an        <= N_DIGITS'(1);
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) begin
        digit_idx <= idx_next;
        snapshot  <= snap_next;
        segs      <= segs_next;
        an        <= an_next;
      end
    end
  end

endmodule

// File: tb/tb_lab_monitor.sv
// Directed plus randomized bench for lab_monitor, checked every cycle against a
// window-based debounce model and a decimal display model.
module tb_lab_monitor;

  localparam int N_COMPS         = 16;
  localparam int N_DIGITS        = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int SCAN_DIV        = 4;
  localparam int FRAME           = SCAN_DIV * N_DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] comps = 16'hFFFF;
  logic        show_peak = 1'b0;
  logic        clear_peak = 1'b0;
  logic [4:0]  count;
  logic [4:0]  peak;
  logic        full;
  logic        empty;
  logic [6:0]  segs;
  logic [1:0]  an;

  lab_monitor #(
    .N_COMPS(N_COMPS),
    .N_DIGITS(N_DIGITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .comps(comps),
    .show_peak(show_peak),
    .clear_peak(clear_peak),
    .count(count),
    .peak(peak),
    .full(full),
    .empty(empty),
    .segs(segs),
    .an(an)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // Reference model state: edges since reset release, raw input history, accepted lines.
  int          e;
  logic [15:0] hist[$];
  logic [15:0] mstab;
  int          mcount;
  int          mpeak;
  int          msnap;

  function automatic logic [15:0] raw(input int k);
    if (k >= 1 && k <= hist.size()) return hist[k-1];
    return 16'hFFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    e = 0;
    hist.delete();
    mstab  = 16'hFFFF;
    mcount = 0;
    mpeak  = 0;
    msnap  = 0;
  endtask

  task automatic check_all(input string ph);
    int idx;
    logic [6:0] exp_segs;
    idx = (e / SCAN_DIV) % N_DIGITS;
    if (idx == 0) exp_segs = seg_tab[msnap % 10];
    else exp_segs = (msnap < 10) ? 7'd0 : seg_tab[(msnap / 10) % 10];
    chk({ph, ".count"}, count, mcount);
    chk({ph, ".peak"}, peak, mpeak);
    chk({ph, ".full"}, full, (mcount == N_COMPS) ? 1 : 0);
    chk({ph, ".empty"}, empty, (mcount == 0) ? 1 : 0);
    chk({ph, ".an"}, an, 1 << idx);
    chk({ph, ".segs"}, segs, exp_segs);
  endtask

  task automatic step();
    logic [15:0] nstab;
    logic [15:0] r;
    int ncount;
    int npeak;
    bit flip;
    @(posedge clk);
    e++;
    hist.push_back(comps);
    ncount = $countones(~mstab);
    npeak  = clear_peak ? mcount : ((mcount > mpeak) ? mcount : mpeak);
    nstab  = mstab;
    for (int b = 0; b < N_COMPS; b++) begin
      flip = 1'b1;
      for (int j = 0; j < DEBOUNCE_CYCLES; j++) begin
        r = raw(e - 2 - j);
        if (r[b] == mstab[b]) flip = 1'b0;
      end
      if (flip) nstab[b] = ~mstab[b];
    end
    if (e % FRAME == 0) msnap = show_peak ? mpeak : mcount;
    mstab  = nstab;
    mcount = ncount;
    mpeak  = npeak;
    #1;
    check_all("cyc");
  endtask

  task automatic to_frame();
    for (int i = 0; i < FRAME && (e % FRAME) != 0; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    comps = 16'hFFFE;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("latency.count", count, (i < 7) ? 0 : 1);
      chk("latency.empty", empty, (i < 7) ? 1 : 0);
    end

    comps = 16'hFFFF;
    repeat (10) step();
    comps = 16'hFFF7;
    repeat (3) step();
    comps = 16'hFFFF;
    repeat (10) begin
      step();
      chk("glitch3.count", count, 0);
    end
    comps = 16'hFFF7;
    repeat (4) step();
    comps = 16'hFFFF;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (count == 5'd1) seen = 1'b1;
    end
    chk("glitch4.seen", seen, 1);
    chk("glitch4.after", count, 0);

    comps = 16'h0000;
    repeat (10) step();
    chk("full.count", count, 16);
    chk("full.full", full, 1);
    to_frame();
    chk("full.an0", an, 2'b01);
    chk("full.seg0", segs, 7'b1111101);
    repeat (SCAN_DIV) step();
    chk("full.an1", an, 2'b10);
    chk("full.seg1", segs, 7'b0000110);

    comps = 16'hFFE0;
    repeat (10) step();
    clear_peak = 1'b1;
    step();
    clear_peak = 1'b0;
    chk("peak.clr5", peak, 5);
    comps = 16'hFFFC;
    repeat (10) step();
    chk("peak.count2", count, 2);
    chk("peak.hold5", peak, 5);
    show_peak = 1'b1;
    step();
    to_frame();
    chk("peak.an0", an, 2'b01);
    chk("peak.seg0", segs, 7'b1101101);
    repeat (SCAN_DIV) step();
    chk("peak.an1", an, 2'b10);
    chk("peak.seg1", segs, 7'b0000000);
    show_peak = 1'b0;
    clear_peak = 1'b1;
    step();
    clear_peak = 1'b0;
    chk("peak.clr2", peak, 2);
    comps = 16'hFFF8;
    repeat (6) step();
    clear_peak = 1'b1;
    step();
    clear_peak = 1'b0;
    step();
    chk("peak.rise3", peak, 3);

    comps = 16'hFE00;
    repeat (10) step();
    to_frame();
    chk("blank9.seg0", segs, 7'b1101111);
    repeat (SCAN_DIV) step();
    chk("blank9.seg1", segs, 7'b0000000);
    comps = 16'hFC00;
    repeat (10) step();
    to_frame();
    chk("ten.seg0", segs, 7'b0111111);
    repeat (SCAN_DIV) step();
    chk("ten.an1", an, 2'b10);
    chk("ten.seg1", segs, 7'b0000110);

    repeat (600) begin
      if ($urandom_range(0, 19) == 0) comps = 16'($urandom);
      else if ($urandom_range(0, 5) == 0) comps[$urandom_range(0, 15)] = ~comps[$urandom_range(0, 15)];
      if ($urandom_range(0, 39) == 0) show_peak = ~show_peak;
      clear_peak = ($urandom_range(0, 29) == 0);
      step();
    end
    clear_peak = 1'b0;
    show_peak = 1'b0;

    comps = 16'hFF80;
    repeat (10) step();
    chk("rst.pre7", count, 7);
    for (int i = 0; i < SCAN_DIV && (e % SCAN_DIV) != 2; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.count", count, 0);
    chk("rst.peak", peak, 0);
    chk("rst.empty", empty, 1);
    chk("rst.an", an, 2'b01);
    chk("rst.segs", segs, 7'b0111111);
    model_reset();
    check_all("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();
    chk("rst.recover7", count, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
